// File: rtl/pixel_cmd_engine.sv
// Pixel command engine: detects toggled command words from the set-pixel PIO, queues them,
// and executes them as Avalon-MM writes (single pixel or full-screen fill) into the framebuffer.
module pixel_cmd_engine #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cmd_in,
  output logic [ADDR_W-1:0] fb_address,
  output logic              fb_write,
  output logic [COLOR_W-1:0] fb_writedata,
  input  logic              fb_waitrequest,
  output logic [31:0]       status,
  output logic [1:0]        state_dbg
);

  // Handshake: a framebuffer write transfers on a rising edge where fb_write=1 and
  // fb_waitrequest=0; address, data and fb_write are held unchanged until that edge.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + COLOR_W + 19;
  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PIXEL = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic             toggle_prev;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty, fifo_full;
  logic             new_cmd, push, pop, ovf_drop;

  logic [ENT_W-1:0]   head;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [COLOR_W-1:0] head_col;
  logic               head_op;
  logic               in_range;
  logic [31:0]        pix_lin;

  logic [ADDR_W-1:0]  addr_nx;
  logic [COLOR_W-1:0] data_nx;
  logic               write_nx;
  logic               done_inc, bad_drop;

  logic        overflow;
  logic [7:0]  dropped_cnt;
  logic [15:0] completed_cnt;
  logic [1:0]  drop_n;
  logic [8:0]  drop_sum;
  logic        unused_bits;

  assign new_cmd    = cmd_in[31] ^ toggle_prev;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push       = new_cmd && !fifo_full;
  assign ovf_drop   = new_cmd && fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;

  assign head     = mem[rd_ptr];
  assign head_x   = head[9:0];
  assign head_y   = head[18:10];
  assign head_col = head[19 +: COLOR_W];
  assign head_op  = head[ENT_W-1];
  assign in_range = ({22'd0, head_x} < H_LIM) && ({23'd0, head_y} < V_LIM);
  assign pix_lin  = {23'd0, head_y} * H_LIM + {22'd0, head_x};

  // Reserved command bits and the upper product bits beyond the address width are discarded.
  assign unused_bits = ^{cmd_in[29:27], pix_lin[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_in[30], cmd_in[19 +: COLOR_W], cmd_in[18:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_prev <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (new_cmd) toggle_prev <= cmd_in[31];
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = fb_address;
    data_nx  = fb_writedata;
    write_nx = fb_write;
    done_inc = 1'b0;
    bad_drop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_op) begin
            addr_nx  = '0;
            data_nx  = head_col;
            write_nx = 1'b1;
            state_nx = FILL;
          end else if (in_range) begin
            addr_nx  = pix_lin[ADDR_W-1:0];
            data_nx  = head_col;
            write_nx = 1'b1;
            state_nx = PIXEL;
          end else begin
            bad_drop = 1'b1;
          end
        end
      end
      PIXEL: begin
        if (!fb_waitrequest) begin
          write_nx = 1'b0;
          done_inc = 1'b1;
          state_nx = IDLE;
        end
      end
      FILL: begin
        if (!fb_waitrequest) begin
          if (fb_address == LAST_ADDR) begin
            write_nx = 1'b0;
            done_inc = 1'b1;
            state_nx = IDLE;
          end else begin
            addr_nx = fb_address + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A FIFO overflow and an out-of-range pixel can be dropped on the same edge.
  assign drop_n   = {1'b0, ovf_drop} + {1'b0, bad_drop};
  assign drop_sum = {1'b0, dropped_cnt} + {7'd0, drop_n};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      fb_address    <= '0;
      fb_writedata  <= '0;
      fb_write      <= 1'b0;
      overflow      <= 1'b0;
      dropped_cnt   <= '0;
      completed_cnt <= '0;
    end else begin
      state        <= state_nx;
      fb_address   <= addr_nx;
      fb_writedata <= data_nx;
      fb_write     <= write_nx;
      if (ovf_drop) overflow <= 1'b1;
      dropped_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (done_inc) completed_cnt <= completed_cnt + 16'd1;
    end
  end

  assign status    = {completed_cnt, dropped_cnt, 5'd0, overflow, fifo_full,
                      (state != IDLE) || !fifo_empty};
  assign state_dbg = state;

endmodule

// File: tb/tb_pixel_cmd_engine.sv
// Bench for pixel_cmd_engine: a full-size instance for pixel addressing/latency and an 8x4
// instance for fills, stalls, overflow, reset abort and randomized command bursts.
module tb_pixel_cmd_engine;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [31:0] cmd_b, status_b;
  logic        wait_b, wr_b;
  logic [18:0] addr_b;
  logic [7:0]  data_b;
  logic [1:0]  st_b;

  logic [31:0] cmd_s, status_s;
  logic        wait_s, wr_s;
  logic [18:0] addr_s;
  logic [7:0]  data_s;
  logic [1:0]  st_s;

  pixel_cmd_engine dut_big (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_b), .fb_address(addr_b), .fb_write(wr_b),
    .fb_writedata(data_b), .fb_waitrequest(wait_b), .status(status_b), .state_dbg(st_b)
  );

  pixel_cmd_engine #(.H_RES(8), .V_RES(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_s), .fb_address(addr_s), .fb_write(wr_s),
    .fb_writedata(data_s), .fb_waitrequest(wait_s), .status(status_s), .state_dbg(st_s)
  );

  localparam int SW = 8;
  localparam int SH = 4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model for the small instance: expected write stream plus status counters.
  logic [26:0] exp_q[$];
  int          exp_comp, exp_drop;
  logic        exp_ovf;
  logic        tog_s, tog_b;
  int          small_wr, big_wr;
  logic [18:0] big_addr;
  logic [7:0]  big_data;
  bit          rand_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic op, input logic [9:0] x, input logic [8:0] y,
                        input logic [7:0] col, input logic [2:0] rsv, input bit will_drop);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    tog_s = ~tog_s;
    cmd_s = {tog_s, op, rsv, col, y, x};
    if (will_drop) begin
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      exp_ovf  = 1'b1;
    end else if (op) begin
      for (int a = 0; a < SW * SH; a++) exp_q.push_back({19'(a), col});
      exp_comp++;
    end else if (ix < SW && iy < SH) begin
      exp_q.push_back({19'(iy * SW + ix), col});
      exp_comp++;
    end else begin
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
    end
  endtask

  task automatic wait_idle_s(input int limit);
    int c;
    c = 0;
    tick(1);
    while (status_s[0] !== 1'b0 && c < limit) begin
      tick(1);
      c++;
    end
    check("idle_timeout_s", 32'(status_s[0]), 32'd0);
  endtask

  task automatic check_status_s();
    check("completed_s", 32'(status_s[31:16]), 32'(exp_comp & 16'hFFFF));
    check("dropped_s", 32'(status_s[15:8]), 32'(exp_drop));
    check("overflow_s", 32'(status_s[2]), 32'(exp_ovf));
    check("fifo_full_s", 32'(status_s[1]), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && wr_s && !wait_s) begin
      small_wr++;
      if (exp_q.size() == 0) begin
        check("spurious_write_s", 32'(wr_s), 32'd0);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        check("wr_addr_s", 32'(addr_s), 32'(e[26:8]));
        check("wr_data_s", 32'(data_s), 32'(e[7:0]));
      end
    end
    if (reset_n && wr_b && !wait_b) begin
      big_wr++;
      big_addr = addr_b;
      big_data = data_b;
    end
  end

  always @(posedge clk) begin
    if (rand_wait) begin
      #1;
      wait_s = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] hold_addr;
    logic [7:0]  hold_data;
    int          base_wr, c;

    reset_n = 1'b0;
    cmd_b = '0; cmd_s = '0; wait_b = 1'b0; wait_s = 1'b0;
    tog_s = 1'b0; tog_b = 1'b0; rand_wait = 1'b0;
    exp_comp = 0; exp_drop = 0; exp_ovf = 1'b0;
    small_wr = 0; big_wr = 0; big_addr = '0; big_data = '0;

    tick(2);
    check("rst_write_s", 32'(wr_s), 32'd0);
    check("rst_addr_s", 32'(addr_s), 32'd0);
    check("rst_status_s", status_s, 32'd0);
    check("rst_status_b", status_b, 32'd0);
    check("rst_state_s", 32'(st_s), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Full-size pixel write and its two-cycle latency.
    tog_b = 1'b1;
    cmd_b = 32'h8000_0000 | (32'd2 << 10) | 32'd5 | (32'hE0 << 19);
    @(posedge clk);
    @(negedge clk);
    check("latency_edge_k", 32'(wr_b), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_edge_k1", 32'(wr_b), 32'd1);
    check("pix_addr_b", 32'(addr_b), 32'd1285);
    check("pix_data_b", 32'(data_b), 32'hE0);
    tick(4);
    check("big_writes", 32'(big_wr), 32'd1);
    check("big_addr", 32'(big_addr), 32'd1285);
    check("big_data", 32'(big_data), 32'hE0);
    check("big_completed", 32'(status_b[31:16]), 32'd1);
    check("big_busy", 32'(status_b[0]), 32'd0);

    // Out-of-range x is dropped without a write.
    tog_b = 1'b0;
    cmd_b = {1'b0, 1'b0, 3'd0, 8'h33, 9'd0, 10'd640};
    tick(5);
    check("oor_no_write", 32'(big_wr), 32'd1);
    check("oor_dropped", 32'(status_b[15:8]), 32'd1);
    check("oor_completed", 32'(status_b[31:16]), 32'd1);
    check("oor_busy", 32'(status_b[0]), 32'd0);

    // Fill on the 8x4 instance.
    base_wr = small_wr;
    send_s(1'b1, 10'd0, 9'd0, 8'h1C, 3'd0, 1'b0);
    wait_idle_s(200);
    check("fill_write_count", 32'(small_wr - base_wr), 32'd32);
    check_status_s();

    // Stalled pixel write must hold address, data and request stable.
    wait_s = 1'b1;
    send_s(1'b0, 10'd3, 9'd2, 8'h55, 3'd5, 1'b0);
    c = 0;
    while (wr_s !== 1'b1 && c < 10) begin tick(1); c++; end
    hold_addr = 19'd19;
    hold_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_write", 32'(wr_s), 32'd1);
      check("stall_addr", 32'(addr_s), 32'(hold_addr));
      check("stall_data", 32'(data_s), 32'(hold_data));
    end
    tick(1);
    base_wr = small_wr;
    wait_s = 1'b0;
    tick(3);
    check("stall_one_accept", 32'(small_wr - base_wr), 32'd1);
    check("stall_write_low", 32'(wr_s), 32'd0);
    check_status_s();

    // Overflow: one command in the FSM, four queued, the sixth dropped.
    wait_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_s(1'b0, 10'(i), 9'd1, 8'($urandom), 3'd0, i == 5);
      tick(1);
    end
    tick(1);
    check("ovf_fifo_full", 32'(status_s[1]), 32'd1);
    check("ovf_flag", 32'(status_s[2]), 32'd1);
    check("ovf_dropped", 32'(status_s[15:8]), 32'(exp_drop));
    check("ovf_busy", 32'(status_s[0]), 32'd1);
    wait_s = 1'b0;
    wait_idle_s(100);
    check_status_s();

    // Randomized bursts under random stalls.
    rand_wait = 1'b1;
    for (int b = 0; b < 30; b++) begin
      int k;
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        send_s($urandom_range(0, 7) == 0, 10'($urandom_range(0, 9)), 9'($urandom_range(0, 5)),
               8'($urandom), 3'($urandom), 1'b0);
        tick($urandom_range(1, 3));
      end
      wait_idle_s(3000);
      check_status_s();
    end
    rand_wait = 1'b0;
    tick(1);
    wait_s = 1'b0;
    tick(1);

    // Reset in the middle of a fill.
    send_s(1'b1, 10'd0, 9'd0, 8'hA5, 3'd0, 1'b0);
    tick(12);
    reset_n = 1'b0;
    #1;
    check("abort_write", 32'(wr_s), 32'd0);
    check("abort_status", status_s, 32'd0);
    check("abort_state", 32'(st_s), 32'd0);
    exp_q.delete();
    exp_comp = 0; exp_drop = 0; exp_ovf = 1'b0;
    tog_s = 1'b0; cmd_s = '0; tog_b = 1'b0; cmd_b = '0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    send_s(1'b0, 10'd7, 9'd3, 8'h0F, 3'd0, 1'b0);
    wait_idle_s(50);
    check_status_s();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
